fp_add_seq_ctrl: RTL and testbench

Multi-cycle sequencer for the single-precision floating-point adder. It accepts two IEEE-754 binary32 operands over a valid/ready handshake and unpacks them. It then steps the fraction datapath through exponent alignment, the signed fraction add (bigalu semantics: two's-complement conversion per sign, add, flags) and normalization, and returns a packed result. It sits between the operand source and the result consumer and owns all sequencing of the fraction ALU.

---
 rtl/fp_add_seq_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_fp_add_seq_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_seq_ctrl.sv
// Multi-cycle sequencer for a binary32 adder: unpack, align, signed add, normalize, pack.
// Latency: 1 accept + Diff ALIGN (0 when Diff >= ALIGN_MAX) + 1 ADD + n NORM cycles to OutValid.
// Backpressure: InReady only in IDLE; result and flags held in DONE until OutReady.
module fp_add_seq_ctrl #(
  parameter int EXP_W     = 8,
  parameter int FRAC_W    = 23,
  parameter int ALIGN_MAX = 25
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    InValid,
  output logic                    InReady,
  input  logic [EXP_W+FRAC_W:0]   OpA,
  input  logic [EXP_W+FRAC_W:0]   OpB,
  output logic                    OutValid,
  input  logic                    OutReady,
  output logic [EXP_W+FRAC_W:0]   Result,
  output logic                    ccz,
  output logic                    ccn,
  output logic                    ccv
);

  // Magnitude carries the hidden bit; the sum needs one carry bit and one sign bit on top.
  localparam int MAG_W = FRAC_W + 1;
  localparam int SUM_W = FRAC_W + 3;
  localparam logic [EXP_W-1:0] ALIGN_LIM = EXP_W'(ALIGN_MAX);
  localparam logic [EXP_W-1:0] EXP_ONE   = EXP_W'(1);
  // Incrementing from this exponent (or above) saturates to infinity.
  localparam logic [EXP_W-1:0] EXP_OVF   = {{(EXP_W-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

  state_t             state;
  logic               sign_l;
  logic               sign_s;
  logic [MAG_W-1:0]   mag_l;
  logic [MAG_W-1:0]   mag_s;
  logic [EXP_W-1:0]   exp_w;
  logic [EXP_W-1:0]   diff;
  logic [SUM_W-1:0]   mag;
  logic               sign_r;

  logic               a_sign;
  logic               b_sign;
  logic [EXP_W-1:0]   a_exp;
  logic [EXP_W-1:0]   b_exp;
  logic [MAG_W-1:0]   a_mag;
  logic [MAG_W-1:0]   b_mag;
  logic               a_big;
  logic [EXP_W-1:0]   in_diff;

  logic [SUM_W-1:0]   ext_l;
  logic [SUM_W-1:0]   ext_s;
  logic [SUM_W-1:0]   term_l;
  logic [SUM_W-1:0]   term_s;
  logic [SUM_W-1:0]   sum;
  logic               sum_sign;
  logic [SUM_W-1:0]   sum_abs;

  // Unpack both operands and pick the larger-exponent one (A wins a tie); denormals flush to zero.
  always_comb begin
    a_sign  = OpA[EXP_W+FRAC_W];
    b_sign  = OpB[EXP_W+FRAC_W];
    a_exp   = OpA[EXP_W+FRAC_W-1:FRAC_W];
    b_exp   = OpB[EXP_W+FRAC_W-1:FRAC_W];
    a_mag   = (a_exp == '0) ? '0 : {1'b1, OpA[FRAC_W-1:0]};
    b_mag   = (b_exp == '0) ? '0 : {1'b1, OpB[FRAC_W-1:0]};
    a_big   = (a_exp >= b_exp);
    in_diff = a_big ? (a_exp - b_exp) : (b_exp - a_exp);
  end

  // Signed fraction add: two's-complement each magnitude by its sign, add, take sign and |sum|.
  always_comb begin
    ext_l    = {2'b00, mag_l};
    ext_s    = {2'b00, mag_s};
    term_l   = sign_l ? ('0 - ext_l) : ext_l;
    term_s   = sign_s ? ('0 - ext_s) : ext_s;
    sum      = term_l + term_s;
    sum_sign = sum[SUM_W-1];
    sum_abs  = sum_sign ? ('0 - sum) : sum;
  end

  // Sequencer FSM with registered handshake, result and flag outputs.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= IDLE;
      InReady  <= 1'b0;
      OutValid <= 1'b0;
      Result   <= '0;
      ccz      <= 1'b0;
      ccn      <= 1'b0;
      ccv      <= 1'b0;
      sign_l   <= 1'b0;
      sign_s   <= 1'b0;
      mag_l    <= '0;
      mag_s    <= '0;
      exp_w    <= '0;
      diff     <= '0;
      mag      <= '0;
      sign_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (InReady && InValid) begin
            InReady <= 1'b0;
            exp_w   <= a_big ? a_exp  : b_exp;
            sign_l  <= a_big ? a_sign : b_sign;
            sign_s  <= a_big ? b_sign : a_sign;
            mag_l   <= a_big ? a_mag  : b_mag;
            diff    <= in_diff;
            if (in_diff >= ALIGN_LIM) begin
              mag_s <= '0;
              state <= ADD;
            end else if (in_diff == '0) begin
              mag_s <= a_big ? b_mag : a_mag;
              state <= ADD;
            end else begin
              mag_s <= a_big ? b_mag : a_mag;
              state <= ALIGN;
            end
          end else begin
            InReady <= 1'b1;
          end
        end
        ALIGN: begin
          // Shifted-out bits are dropped, so alignment truncates toward zero.
          mag_s <= mag_s >> 1;
          diff  <= diff - 1'b1;
          if (diff == EXP_ONE) state <= ADD;
        end
        ADD: begin
          mag    <= sum_abs;
          sign_r <= sum_sign;
          state  <= NORM;
        end
        NORM: begin
          if (mag == '0) begin
            Result   <= '0;
            ccz      <= 1'b1;
            ccn      <= 1'b0;
            ccv      <= 1'b0;
            OutValid <= 1'b1;
            state    <= DONE;
          end else if (mag[MAG_W]) begin
            if (exp_w >= EXP_OVF) begin
              Result   <= {sign_r, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
              ccz      <= 1'b0;
              ccn      <= sign_r;
              ccv      <= 1'b1;
              OutValid <= 1'b1;
              state    <= DONE;
            end else begin
              mag   <= mag >> 1;
              exp_w <= exp_w + 1'b1;
            end
          end else if (!mag[MAG_W-1]) begin
            if (exp_w <= EXP_ONE) begin
              // Underflow: keep the sign, flush the value to zero.
              Result   <= {sign_r, {(EXP_W+FRAC_W){1'b0}}};
              ccz      <= 1'b1;
              ccn      <= sign_r;
              ccv      <= 1'b0;
              OutValid <= 1'b1;
              state    <= DONE;
            end else begin
              mag   <= mag << 1;
              exp_w <= exp_w - 1'b1;
            end
          end else begin
            Result   <= {sign_r, exp_w, mag[FRAC_W-1:0]};
            ccz      <= 1'b0;
            ccn      <= sign_r;
            ccv      <= 1'b0;
            OutValid <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          if (OutReady) begin
            OutValid <= 1'b0;
            InReady  <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_seq_ctrl.sv
// Directed bench for fp_add_seq_ctrl with a queue-based scoreboard.
// Driver pushes the hand-computed result, flags and latency at each accept.
// Monitor pops on each new OutValid and checks hold stability and IDLE return.
module tb_fp_add_seq_ctrl;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        InValid = 1'b0;
  logic        InReady;
  logic [31:0] OpA = '0;
  logic [31:0] OpB = '0;
  logic        OutValid;
  logic        OutReady = 1'b1;
  logic [31:0] Result;
  logic        ccz;
  logic        ccn;
  logic        ccv;

  fp_add_seq_ctrl dut (
    .Clock(Clock), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .OpA(OpA), .OpB(OpB), .OutValid(OutValid), .OutReady(OutReady),
    .Result(Result), .ccz(ccz), .ccn(ccn), .ccv(ccv)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [2:0]  flg;   // {ccz, ccn, ccv}
    int          lat;
    int          hold;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  flg;
    int          lat;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  vec_t vq[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   out_count = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic [31:0] res,
                              input logic [2:0] flg, input int lat, input int hold);
    vec_t v;
    v.a = a; v.b = b; v.res = res; v.flg = flg; v.lat = lat; v.hold = hold;
    return v;
  endfunction

  // Monitor: scoreboard pop on first OutValid cycle, stability while held, IDLE after handoff.
  logic prev_vld = 1'b0;
  logic have_cur = 1'b0;
  exp_t cur;
  always @(negedge Clock) begin
    if (OutValid) begin
      if (!prev_vld) begin
        out_count++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          have_cur = 1'b0;
          $display("FAIL unexpected_output: got Result %h, expected no output", Result);
        end else begin
          cur = exp_q.pop_front();
          have_cur = 1'b1;
          check("result", Result, cur.res);
          check("flags", {29'd0, ccz, ccn, ccv}, {29'd0, cur.flg});
          check("latency", 32'(cyc - cur.acc), 32'(cur.lat));
        end
      end else if (have_cur) begin
        check("held_result", Result, cur.res);
        check("held_flags", {29'd0, ccz, ccn, ccv}, {29'd0, cur.flg});
        check("inready_in_done", {31'd0, InReady}, 32'd0);
      end
    end else if (prev_vld) begin
      check("inready_after_handoff", {31'd0, InReady}, 32'd1);
    end
    prev_vld = OutValid;
  end

  task automatic run_vec(input vec_t v);
    int n;
    exp_t e;
    @(negedge Clock);
    OpA = v.a;
    OpB = v.b;
    InValid = 1'b1;
    OutReady = (v.hold == 0);
    n = 0;
    while (!InReady && n < 100) begin
      @(negedge Clock);
      n++;
    end
    if (!InReady) begin
      check("accept_timeout", {31'd0, InReady}, 32'd1);
      InValid = 1'b0;
      OutReady = 1'b1;
      return;
    end
    e.res = v.res; e.flg = v.flg; e.lat = v.lat; e.acc = cyc;
    exp_q.push_back(e);
    @(negedge Clock);
    InValid = 1'b0;
    OpA = $urandom;
    OpB = $urandom;
    if (v.hold > 0) begin
      n = 0;
      while (!OutValid && n < 200) begin
        @(negedge Clock);
        n++;
      end
      repeat (v.hold) @(negedge Clock);
      OutReady = 1'b1;
    end
    n = 0;
    while ((exp_q.size() != 0 || OutValid) && n < 200) begin
      @(negedge Clock);
      n++;
    end
    if (exp_q.size() != 0 || OutValid) begin
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    OutReady = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    // Flags {ccz, ccn, ccv}
    vq.push_back(mk(32'h3F800000, 32'h3F800000, 32'h40000000, 3'b000,  4, 0));
    vq.push_back(mk(32'h3F800000, 32'h40000000, 32'h40400000, 3'b000,  4, 0));
    vq.push_back(mk(32'h3F800000, 32'hBF800000, 32'h00000000, 3'b100,  3, 0));
    vq.push_back(mk(32'h3FC00000, 32'hBF800000, 32'h3F000000, 3'b000,  4, 0));
    vq.push_back(mk(32'h4B800000, 32'h3F800000, 32'h4B800000, 3'b000, 27, 0));
    vq.push_back(mk(32'h4C800000, 32'h3F800000, 32'h4C800000, 3'b000,  3, 0));
    vq.push_back(mk(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 3'b001,  3, 0));
    vq.push_back(mk(32'hFF7FFFFF, 32'hFF7FFFFF, 32'hFF800000, 3'b011,  3, 0));
    vq.push_back(mk(32'hBF800000, 32'hBF800000, 32'hC0000000, 3'b010,  4, 0));
    vq.push_back(mk(32'h00000000, 32'h3F800000, 32'h3F800000, 3'b000,  3, 0));
    vq.push_back(mk(32'h40000000, 32'hBF800000, 32'h3F800000, 3'b000,  5, 0));
    vq.push_back(mk(32'h3F800001, 32'h3F800000, 32'h40000000, 3'b000,  4, 0));
    vq.push_back(mk(32'h3F800000, 32'h40000000, 32'h40400000, 3'b000,  4, 5));
    vq.push_back(mk(32'h80800001, 32'h00800000, 32'h80000000, 3'b110,  3, 0));

    // Reset state
    repeat (3) @(negedge Clock);
    check("rst_inready", {31'd0, InReady}, 32'd0);
    check("rst_outvalid", {31'd0, OutValid}, 32'd0);
    check("rst_result", Result, 32'd0);
    check("rst_flags", {29'd0, ccz, ccn, ccv}, 32'd0);
    Reset = 1'b0;
    @(negedge Clock);
    check("inready_after_reset", {31'd0, InReady}, 32'd1);

    foreach (vq[i]) run_vec(vq[i]);

    // Reset mid-ALIGN: the in-flight result must never appear, flags clear.
    @(negedge Clock);
    OpA = 32'h4B800000;
    OpB = 32'h3F800000;
    InValid = 1'b1;
    n0 = 0;
    while (!InReady && n0 < 100) begin
      @(negedge Clock);
      n0++;
    end
    @(negedge Clock);
    InValid = 1'b0;
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    check("midrst_outvalid", {31'd0, OutValid}, 32'd0);
    check("midrst_result", Result, 32'd0);
    check("midrst_flags", {29'd0, ccz, ccn, ccv}, 32'd0);
    n0 = out_count;
    repeat (40) @(negedge Clock);
    check("midrst_no_output", 32'(out_count), 32'(n0));
    check("midrst_inready", {31'd0, InReady}, 32'd1);

    // Normal operation resumes after the aborted one.
    run_vec(mk(32'h3F800000, 32'h3F800000, 32'h40000000, 3'b000, 4, 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
